// File: rtl/mem_ctrl_pkg.sv
// Shared types and codebase defaults for the memory controller slice.
// Holds the arbiter FSM state type and the default memory geometry.
package mem_ctrl_pkg;

    localparam int DATA_SIZE  = 8;
    localparam int ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ_1 = 2'd2,
        READ_2 = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner select for the memory arbiter.
// Default build: round-robin, searching upward from last_gnt+1 (mod NUM_REQ).
// Build option MEM_ARB_FIXED_PRIO_EN: lowest-index requester always wins,
// and last_gnt is ignored.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [IDX_W-1:0] cand;

    // Pick the first requesting index in priority order
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        // Walk downward so the lowest index is the last one to overwrite.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_vld   = 1'b1;
            end
        end
`else
        // Offsets 1..NUM_REQ visit every index once, last_gnt itself last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_gnt) + off) % NUM_REQ);
            if (!gnt_vld && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_vld   = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between NUM_REQ
// requesters. Latches the winner's command, drives the memory enables,
// captures read data and returns a one-cycle done pulse to the winner.
// All outputs are registered. Build option MEM_ARB_FIXED_PRIO_EN selects
// fixed priority (lowest index wins) instead of round-robin.
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_SIZE  = mem_ctrl_pkg::DATA_SIZE,
    parameter int ADDR_WIDTH = mem_ctrl_pkg::ADDR_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_SIZE-1:0]          rdata,
    output logic                          busy,
    output logic                          mem_readEnable,
    output logic                          mem_writeEnable,
    output logic [ADDR_WIDTH-1:0]         mem_rwAddr,
    output logic [DATA_SIZE-1:0]          mem_writeData_in,
    input  logic [DATA_SIZE-1:0]          mem_readData_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t state_q, state_d;

    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [NUM_REQ-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]      last_gnt_q, last_gnt_d;
    logic [DATA_SIZE-1:0]  rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  re_q, re_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0]  wdata_q, wdata_d;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_vld;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req      (req),
        .last_gnt (last_gnt_q),
        .gnt      (arb_gnt),
        .gnt_idx  (arb_idx),
        .gnt_vld  (arb_vld)
    );

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: writes take one memory cycle, reads take two
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = req_we[arb_idx] ? WRITE : READ_1;
                end
            end
            WRITE:   state_d = IDLE;
            READ_1:  state_d = READ_2;
            READ_2:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; gnt and done default low so they pulse
    always_comb begin
        gnt_d      = '0;
        done_d     = '0;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        re_d       = re_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    gnt_d      = arb_gnt;
                    owner_d    = arb_gnt;
                    last_gnt_d = arb_idx;
                    addr_d     = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d    = req_wdata[arb_idx*DATA_SIZE +: DATA_SIZE];
                    busy_d     = 1'b1;
                    // Exactly one enable is raised; the other is already low.
                    we_d       = req_we[arb_idx];
                    re_d       = !req_we[arb_idx];
                end
            end
            WRITE: begin
                we_d   = 1'b0;
                done_d = owner_q;
                busy_d = 1'b0;
            end
            READ_1: begin
                re_d = 1'b1;
            end
            READ_2: begin
                rdata_d = mem_readData_out;
                re_d    = 1'b0;
                done_d  = owner_q;
                busy_d  = 1'b0;
            end
            default: begin
                re_d   = 1'b0;
                we_d   = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Output registers; last_gnt resets to the top index so requester 0 wins first
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_q      <= '0;
            done_q     <= '0;
            owner_q    <= '0;
            last_gnt_q <= IDX_W'(NUM_REQ - 1);
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            re_q       <= re_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign gnt              = gnt_q;
    assign done             = done_q;
    assign rdata            = rdata_q;
    assign busy             = busy_q;
    assign mem_readEnable   = re_q;
    assign mem_writeEnable  = we_q;
    assign mem_rwAddr       = addr_q;
    assign mem_writeData_in = wdata_q;

endmodule
